rob_multi_wb: RTL and testbench
===============================

// Module: rob_multi_wb
// PURPOSE
//  Parametrised in-order reorder buffer. Circular queue of 2**ROB_DEPTH_BIT entries with NUM_WB writeback ports.
//  Sits between Decoder (alloc/query), RS/LSB (writeback), RF (commit/dependency) and IFetch (redirect).
//  Adds over the previous ROB: store-commit handshake, EXIT halt state, same-cycle query bypass, one-cycle flush.
// PARAMETERS
//  ROB_DEPTH_BIT  5   log2 entry count (32 entries)
//  NUM_WB         2   writeback ports (port0 = RS, port1 = LSB)
//  XLEN           32  data/address width
// PORTS
//  clk_in           in   1                    clock
//  rst_in           in   1                    reset, synchronous, active-high
//  rdy_in           in   1                    global enable; low = freeze all state
//  alloc_valid      in   1                    Decoder allocates an entry
//  alloc_type       in   2                    REG=0, ST=1, BR=2, EXIT=3
//  alloc_rd         in   5                    dest reg (REG only)
//  alloc_ready_val  in   1                    entry is complete at allocation (lui/auipc/jal)
//  alloc_value      in   XLEN                 result, or link value
//  alloc_pred       in   1                    BR: predicted taken
//  alloc_alt_pc     in   XLEN                 BR: PC of the non-predicted path
//  rob_full         out  1                    count == 2**ROB_DEPTH_BIT
//  rob_free_id      out  ROB_DEPTH_BIT        tail index
//  qry_id           in   2*ROB_DEPTH_BIT      two operand query ids
//  qry_ready        out  2                    per query: entry complete
//  qry_value        out  2*XLEN               per query: value
//  wb_valid         in   NUM_WB               writeback strobes
//  wb_id            in   NUM_WB*ROB_DEPTH_BIT writeback entry ids
//  wb_value         in   NUM_WB*XLEN          results; BR: bit0 = actual taken
//  commit_reg_valid out  1                    RF write pulse
//  commit_rd        out  5                    RF dest
//  commit_value     out  XLEN                 RF data
//  commit_id        out  ROB_DEPTH_BIT        retired entry id (RF clears dependency if it matches)
//  commit_st_valid  out  1                    LSB may perform store commit_id
//  commit_st_ack    in   1                    LSB store done
//  flush            out  1                    one-cycle pipeline clear
//  redirect_pc      out  XLEN                 fetch target, valid with flush
//  halted           out  1                    EXIT retired
// BEHAVIOUR
//  Reset: head=tail=count=0; all valid/ready bits 0; state RUN.
//   All outputs 0 except rob_full=0 and rob_free_id=0.
//  rdy_in=0: no state change; registered outputs hold.
//  Alloc: accepted iff alloc_valid && !rob_full && !flush && state!=HALT.
//   Writes entry[tail]; tail <= tail+1 (mod depth, natural wrap). rob_full uses registered count.
//   Alloc is therefore refused when full even if a retire happens in the same cycle.
//  Count: +1 alloc only; -1 retire only; unchanged if both.
//  Writeback: for each wb_valid, entry[wb_id].ready<=1, value<=wb_value. Ignored if entry invalid or flush=1.
//   Same id on several ports: the highest port index wins.
//  Query, combinational, priority: alloc same cycle with tail==id (alloc_ready_val/alloc_value);
//   then highest-index wb port with matching id; then stored entry.
//  States: RUN, ST_WAIT, HALT.
//  RUN, head valid&&ready:
//   REG  - retire; next cycle commit_reg_valid=1 for 1 cycle with rd/value/id.
//   ST   - commit_st_valid<=1, go to ST_WAIT; no retire yet.
//   BR   - retire. If value[0]!=pred: next cycle flush=1 and redirect_pc=alt_pc.
//          Same edge: head=tail=count=0, all valid bits cleared; same-cycle alloc dropped.
//   EXIT - retire; halted<=1 sticky; go to HALT.
//  ST_WAIT: commit_st_valid stays 1 until commit_st_ack. On ack: retire, drop valid, back to RUN.
//   Ack is ignored in other states.
//  HALT: no commit, no alloc; left only by reset.
//  flush is high for exactly 1 cycle; writebacks and allocs in that cycle are ignored.
//  Reset mid-ST_WAIT returns to RUN with an empty queue; a pending ack is discarded.
//  At most one retire per cycle; latency from ready-at-head to commit pulse = 1 cycle.
// STRUCTURE
//  Shared package/Config.v: ROB type codes (ROB_REG, ROB_ST, ROB_BR, ROB_EXIT), ROB_DEPTH_BIT default, XLEN.
//  Sub-module rob_wb_bypass: combinational NUM_WB priority match for one query id; instantiated twice.
// TESTING
//  Fill: 32 allocs without commit -> rob_full=1 after 32nd; 33rd ignored; rob_free_id=0 (wrapped).
//  REG chain: alloc rd=5 id0, wb port0 id0 value 0x1234 -> next cycle commit_reg_valid, rd=5, value 0x1234, commit_id=0.
//  Bypass: wb port1 id3 value 0xAB in the same cycle as qry id=3 -> qry_ready=1, qry_value=0xAB.
//   Conflict: port0 and port1 both write id3 -> stored value = port1 value.
//  Store: ST at head ready -> commit_st_valid held 4 cycles until ack -> retire; next REG commits the cycle after.
//  Mispredict: BR pred=1, wb bit0=0, alt_pc 0x100, 3 younger entries -> flush=1 for one cycle, redirect_pc=0x100.
//   After flush: count=0, rob_free_id=0.
//  EXIT/reset: EXIT commits -> halted=1, allocs refused; rst_in high 1 cycle -> halted=0, empty queue.

Source files
------------

// File: rtl/rob_multi_wb_pkg.sv
// Shared ROB definitions: entry type codes, control states and default geometry.
package rob_multi_wb_pkg;

    localparam int unsigned ROB_DEPTH_BIT_DEF = 5;
    localparam int unsigned NUM_WB_DEF        = 2;
    localparam int unsigned XLEN_DEF          = 32;
    localparam int unsigned REG_BITS          = 5;
    localparam int unsigned NUM_QRY           = 2;

    typedef enum logic [1:0] {
        ROB_REG  = 2'd0,
        ROB_ST   = 2'd1,
        ROB_BR   = 2'd2,
        ROB_EXIT = 2'd3
    } rob_type_e;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_ST_WAIT = 2'd1,
        S_HALT    = 2'd2
    } rob_state_e;

endpackage

// File: rtl/rob_multi_wb_if.sv
// ROB bus: decoder alloc/query, RS/LSB writeback, RF/LSB commit and fetch redirect.
interface rob_multi_wb_if import rob_multi_wb_pkg::*; #(
    parameter int unsigned ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
    parameter int unsigned NUM_WB        = NUM_WB_DEF,
    parameter int unsigned XLEN          = XLEN_DEF
) ();

    logic                              alloc_valid;
    logic [1:0]                        alloc_type;
    logic [REG_BITS-1:0]               alloc_rd;
    logic                              alloc_ready_val;
    logic [XLEN-1:0]                   alloc_value;
    logic                              alloc_pred;
    logic [XLEN-1:0]                   alloc_alt_pc;
    logic                              rob_full;
    logic [ROB_DEPTH_BIT-1:0]          rob_free_id;
    logic [NUM_QRY*ROB_DEPTH_BIT-1:0]  qry_id;
    logic [NUM_QRY-1:0]                qry_ready;
    logic [NUM_QRY*XLEN-1:0]           qry_value;
    logic [NUM_WB-1:0]                 wb_valid;
    logic [NUM_WB*ROB_DEPTH_BIT-1:0]   wb_id;
    logic [NUM_WB*XLEN-1:0]            wb_value;
    logic                              commit_reg_valid;
    logic [REG_BITS-1:0]               commit_rd;
    logic [XLEN-1:0]                   commit_value;
    logic [ROB_DEPTH_BIT-1:0]          commit_id;
    logic                              commit_st_valid;
    logic                              commit_st_ack;
    logic                              flush;
    logic [XLEN-1:0]                   redirect_pc;
    logic                              halted;

    modport master (
        output alloc_valid, alloc_type, alloc_rd, alloc_ready_val, alloc_value,
               alloc_pred, alloc_alt_pc, qry_id, wb_valid, wb_id, wb_value, commit_st_ack,
        input  rob_full, rob_free_id, qry_ready, qry_value, commit_reg_valid, commit_rd,
               commit_value, commit_id, commit_st_valid, flush, redirect_pc, halted
    );

    modport slave (
        input  alloc_valid, alloc_type, alloc_rd, alloc_ready_val, alloc_value,
               alloc_pred, alloc_alt_pc, qry_id, wb_valid, wb_id, wb_value, commit_st_ack,
        output rob_full, rob_free_id, qry_ready, qry_value, commit_reg_valid, commit_rd,
               commit_value, commit_id, commit_st_valid, flush, redirect_pc, halted
    );

endinterface

// File: rtl/rob_wb_bypass.sv
// Combinational writeback match for one query id; the highest-index matching port wins.
module rob_wb_bypass import rob_multi_wb_pkg::*; #(
    parameter int unsigned ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
    parameter int unsigned NUM_WB        = NUM_WB_DEF,
    parameter int unsigned XLEN          = XLEN_DEF
) (
    input  logic [ROB_DEPTH_BIT-1:0]        qry_id_i,
    input  logic [NUM_WB-1:0]               wb_valid_i,
    input  logic [NUM_WB*ROB_DEPTH_BIT-1:0] wb_id_i,
    input  logic [NUM_WB*XLEN-1:0]          wb_value_i,
    output logic                            hit_o,
    output logic [XLEN-1:0]                 value_o
);

    always_comb begin
        hit_o   = 1'b0;
        value_o = '0;
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p] && (wb_id_i[p*ROB_DEPTH_BIT +: ROB_DEPTH_BIT] == qry_id_i)) begin
                hit_o   = 1'b1;
                value_o = wb_value_i[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rob_multi_wb.sv
// In-order reorder buffer with multi-port writeback, store-commit handshake,
// EXIT halt, same-cycle query bypass and single-cycle mispredict flush.
module rob_multi_wb import rob_multi_wb_pkg::*; #(
    parameter int unsigned ROB_DEPTH_BIT = ROB_DEPTH_BIT_DEF,
    parameter int unsigned NUM_WB        = NUM_WB_DEF,
    parameter int unsigned XLEN          = XLEN_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    rob_multi_wb_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ROB_DEPTH_BIT;

    typedef logic [ROB_DEPTH_BIT-1:0] idx_t;
    typedef logic [ROB_DEPTH_BIT:0]   cnt_t;

    localparam idx_t IDX_ONE = {{(ROB_DEPTH_BIT-1){1'b0}}, 1'b1};
    localparam cnt_t CNT_ONE = {{ROB_DEPTH_BIT{1'b0}}, 1'b1};

    rob_state_e          state_q, state_d;
    idx_t                head_q, head_d;
    idx_t                tail_q, tail_d;
    cnt_t                count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    ready_q, ready_d;

    logic                creg_valid_q, creg_valid_d;
    logic [REG_BITS-1:0] creg_rd_q, creg_rd_d;
    logic [XLEN-1:0]     creg_value_q, creg_value_d;
    idx_t                cid_q, cid_d;
    logic                st_valid_q, st_valid_d;
    logic                flush_q, flush_d;
    logic [XLEN-1:0]     redirect_q, redirect_d;
    logic                halted_q, halted_d;

    rob_type_e           type_q   [DEPTH];
    logic [REG_BITS-1:0] rd_q     [DEPTH];
    logic [XLEN-1:0]     value_q  [DEPTH];
    logic                pred_q   [DEPTH];
    logic [XLEN-1:0]     alt_pc_q [DEPTH];

    logic                rob_full;
    logic                alloc_fire;
    logic                retire;
    logic                mispredict;
    idx_t                wb_idx [NUM_WB];
    logic [NUM_WB-1:0]   wb_fire;

    // count reaches DEPTH exactly when its top bit is set
    assign rob_full   = count_q[ROB_DEPTH_BIT];
    assign alloc_fire = bus.alloc_valid && !rob_full && !flush_q && (state_q != S_HALT);

    always_comb begin
        for (int unsigned p = 0; p < NUM_WB; p++) begin
            wb_idx[p]  = bus.wb_id[p*ROB_DEPTH_BIT +: ROB_DEPTH_BIT];
            wb_fire[p] = bus.wb_valid[p] && valid_q[wb_idx[p]] && !flush_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        valid_d      = valid_q;
        ready_d      = ready_q;
        creg_valid_d = 1'b0;
        creg_rd_d    = creg_rd_q;
        creg_value_d = creg_value_q;
        cid_d        = cid_q;
        st_valid_d   = st_valid_q;
        flush_d      = 1'b0;
        redirect_d   = redirect_q;
        halted_d     = halted_q;
        retire       = 1'b0;
        mispredict   = 1'b0;

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = bus.alloc_ready_val;
            tail_d          = tail_q + IDX_ONE;
        end

        for (int unsigned p = 0; p < NUM_WB; p++) begin
            if (wb_fire[p]) begin
                ready_d[wb_idx[p]] = 1'b1;
            end
        end

        unique case (state_q)
            S_RUN: begin
                if (valid_q[head_q] && ready_q[head_q]) begin
                    unique case (type_q[head_q])
                        ROB_REG: begin
                            retire       = 1'b1;
                            creg_valid_d = 1'b1;
                            creg_rd_d    = rd_q[head_q];
                            creg_value_d = value_q[head_q];
                            cid_d        = head_q;
                        end
                        ROB_ST: begin
                            st_valid_d = 1'b1;
                            cid_d      = head_q;
                            state_d    = S_ST_WAIT;
                        end
                        ROB_BR: begin
                            retire     = 1'b1;
                            mispredict = (value_q[head_q][0] != pred_q[head_q]);
                        end
                        ROB_EXIT: begin
                            retire   = 1'b1;
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                    endcase
                end
            end
            S_ST_WAIT: begin
                if (bus.commit_st_ack) begin
                    retire     = 1'b1;
                    st_valid_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            default: ;
        endcase

        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + IDX_ONE;
        end

        if (alloc_fire && !retire) begin
            count_d = count_q + CNT_ONE;
        end else if (!alloc_fire && retire) begin
            count_d = count_q - CNT_ONE;
        end

        // mispredict overrides this cycle's alloc and writebacks by emptying the queue
        if (mispredict) begin
            flush_d    = 1'b1;
            redirect_d = alt_pc_q[head_q];
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            valid_d    = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            ready_q      <= '0;
            creg_valid_q <= 1'b0;
            creg_rd_q    <= '0;
            creg_value_q <= '0;
            cid_q        <= '0;
            st_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            halted_q     <= 1'b0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            ready_q      <= ready_d;
            creg_valid_q <= creg_valid_d;
            creg_rd_q    <= creg_rd_d;
            creg_value_q <= creg_value_d;
            cid_q        <= cid_d;
            st_valid_q   <= st_valid_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            halted_q     <= halted_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in) begin
            if (alloc_fire) begin
                type_q[tail_q]   <= rob_type_e'(bus.alloc_type);
                rd_q[tail_q]     <= bus.alloc_rd;
                value_q[tail_q]  <= bus.alloc_value;
                pred_q[tail_q]   <= bus.alloc_pred;
                alt_pc_q[tail_q] <= bus.alloc_alt_pc;
            end
            for (int unsigned p = 0; p < NUM_WB; p++) begin
                if (wb_fire[p]) begin
                    value_q[wb_idx[p]] <= bus.wb_value[p*XLEN +: XLEN];
                end
            end
        end
    end

    // query priority: same-cycle alloc at tail, then writeback ports, then stored entry
    for (genvar g = 0; g < NUM_QRY; g++) begin : g_qry
        idx_t            qid;
        logic            byp_hit;
        logic [XLEN-1:0] byp_value;
        logic            q_ready;
        logic [XLEN-1:0] q_value;

        assign qid = bus.qry_id[g*ROB_DEPTH_BIT +: ROB_DEPTH_BIT];

        rob_wb_bypass #(
            .ROB_DEPTH_BIT (ROB_DEPTH_BIT),
            .NUM_WB        (NUM_WB),
            .XLEN          (XLEN)
        ) u_bypass (
            .qry_id_i   (qid),
            .wb_valid_i (bus.wb_valid),
            .wb_id_i    (bus.wb_id),
            .wb_value_i (bus.wb_value),
            .hit_o      (byp_hit),
            .value_o    (byp_value)
        );

        always_comb begin
            q_ready = 1'b0;
            q_value = '0;
            if (alloc_fire && (tail_q == qid)) begin
                q_ready = bus.alloc_ready_val;
                q_value = bus.alloc_value;
            end else if (byp_hit) begin
                q_ready = 1'b1;
                q_value = byp_value;
            end else if (valid_q[qid]) begin
                q_ready = ready_q[qid];
                q_value = value_q[qid];
            end
        end

        assign bus.qry_ready[g]              = q_ready;
        assign bus.qry_value[g*XLEN +: XLEN] = q_value;
    end

    assign bus.rob_full         = rob_full;
    assign bus.rob_free_id      = tail_q;
    assign bus.commit_reg_valid = creg_valid_q;
    assign bus.commit_rd        = creg_rd_q;
    assign bus.commit_value     = creg_value_q;
    assign bus.commit_id        = cid_q;
    assign bus.commit_st_valid  = st_valid_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_pc      = redirect_q;
    assign bus.halted           = halted_q;

endmodule

// File: tb/tb_rob_multi_wb.sv
// Self-checking bench for rob_multi_wb: query vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_rob_multi_wb;
    import rob_multi_wb_pkg::*;

    localparam int B  = 5;
    localparam int NW = 2;
    localparam int XL = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    always #5 clk = ~clk;

    rob_multi_wb_if #(.ROB_DEPTH_BIT(B), .NUM_WB(NW), .XLEN(XL)) bus ();

    rob_multi_wb #(.ROB_DEPTH_BIT(B), .NUM_WB(NW), .XLEN(XL)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid     = 1'b0;
        bus.alloc_type      = 2'd0;
        bus.alloc_rd        = '0;
        bus.alloc_ready_val = 1'b0;
        bus.alloc_value     = '0;
        bus.alloc_pred      = 1'b0;
        bus.alloc_alt_pc    = '0;
        bus.qry_id          = '0;
        bus.wb_valid        = '0;
        bus.wb_id           = '0;
        bus.wb_value        = '0;
        bus.commit_st_ack   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic rv,
                         input logic [31:0] v, input logic pred, input logic [31:0] alt);
        bus.alloc_valid     = 1'b1;
        bus.alloc_type      = t;
        bus.alloc_rd        = rd;
        bus.alloc_ready_val = rv;
        bus.alloc_value     = v;
        bus.alloc_pred      = pred;
        bus.alloc_alt_pc    = alt;
    endtask

    task automatic set_wb(input int p, input logic [4:0] id, input logic [31:0] v);
        bus.wb_valid[p]           = 1'b1;
        bus.wb_id[p*B +: B]       = id;
        bus.wb_value[p*XL +: XL]  = v;
    endtask

    typedef struct {
        logic        av;  logic        arv; logic [31:0] aval;
        logic        w0v; logic [4:0]  w0id; logic [31:0] w0val;
        logic        w1v; logic [4:0]  w1id; logic [31:0] w1val;
        logic [4:0]  qid; logic        erdy; logic [31:0] eval;
    } vec_t;
    vec_t vt [8];

    typedef struct {
        logic [4:0]  id;
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic        rdy;
        logic [31:0] val;
        logic        pred;
        logic [31:0] alt;
    } ment_t;
    ment_t mq[$];
    ment_t ne;

    int          m_tail;
    bit          m_flush, m_creg, m_st, m_stwait;
    logic [4:0]  m_rd, m_cid;
    logic [31:0] m_cval, m_redir;
    bit          acc, pop, mis, flush_now, known;
    logic [4:0]  qsel [2];
    logic        wv [2];
    logic [4:0]  wid [2];
    logic [31:0] wval [2];
    logic        er;
    logic [31:0] ev;
    logic [1:0]  rty;
    int          r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        tick();
        do_reset();

        // reset state
        chk("rst_full", bus.rob_full, 0);
        chk("rst_free_id", bus.rob_free_id, 0);
        chk("rst_creg", bus.commit_reg_valid, 0);
        chk("rst_cval", bus.commit_value, 0);
        chk("rst_st", bus.commit_st_valid, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_redir", bus.redirect_pc, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_qready", bus.qry_ready, 0);
        chk("rst_qvalue", bus.qry_value, 0);

        // fill to capacity
        for (int i = 0; i < 33; i++) begin
            alloc(2'd0, 5'd1, 1'b0, 32'(i), 1'b0, 32'h0);
            tick();
            if (i == 30) chk("fill31_full", bus.rob_full, 0);
            if (i == 31) begin
                chk("fill32_full", bus.rob_full, 1);
                chk("fill32_free_id", bus.rob_free_id, 0);
            end
        end
        idle();
        chk("fill33_full", bus.rob_full, 1);
        chk("fill33_free_id", bus.rob_free_id, 0);

        // REG chain and rdy freeze
        do_reset();
        alloc(2'd0, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        set_wb(0, 5'd0, 32'h1234);
        tick();
        idle();
        chk("reg_early", bus.commit_reg_valid, 0);
        tick();
        chk("reg_valid", bus.commit_reg_valid, 1);
        chk("reg_rd", bus.commit_rd, 5);
        chk("reg_value", bus.commit_value, 32'h1234);
        chk("reg_id", bus.commit_id, 0);
        rdy = 1'b0;
        tick();
        tick();
        chk("freeze_pulse", bus.commit_reg_valid, 1);
        rdy = 1'b1;
        tick();
        chk("reg_pulse_end", bus.commit_reg_valid, 0);

        // query priority table (rdy held low so nothing is committed)
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(2'd0, 5'(i), (i == 2), 32'h10 + 32'(i), 1'b0, 32'h0);
            tick();
        end
        idle();
        vt[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 32'h10};
        vt[1] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd2, 1'b1, 32'h12};
        vt[2] = '{1'b1, 1'b1, 32'h77, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 1'b1, 32'h77};
        vt[3] = '{1'b1, 1'b0, 32'h55, 1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'h99, 5'd4, 1'b0, 32'h55};
        vt[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 5'd3, 32'hA0, 1'b1, 5'd3, 32'hAB, 5'd3, 1'b1, 32'hAB};
        vt[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 5'd3, 32'hA0, 1'b0, 5'd0, 32'h0,  5'd3, 1'b1, 32'hA0};
        vt[6] = '{1'b0, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd1, 32'hB1, 5'd3, 1'b0, 32'h13};
        vt[7] = '{1'b1, 1'b1, 32'h66, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 1'b0, 32'h0};
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (vt[i].av) alloc(2'd0, 5'd9, vt[i].arv, vt[i].aval, 1'b0, 32'h0);
            if (vt[i].w0v) set_wb(0, vt[i].w0id, vt[i].w0val);
            if (vt[i].w1v) set_wb(1, vt[i].w1id, vt[i].w1val);
            bus.qry_id = {vt[i].qid, vt[i].qid};
            #2;
            chk($sformatf("vec%0d_rdy0", i), bus.qry_ready[0], vt[i].erdy);
            chk($sformatf("vec%0d_val0", i), bus.qry_value[31:0], vt[i].eval);
            chk($sformatf("vec%0d_rdy1", i), bus.qry_ready[1], vt[i].erdy);
            chk($sformatf("vec%0d_val1", i), bus.qry_value[63:32], vt[i].eval);
        end
        idle();
        tick();
        chk("freeze_free_id", bus.rob_free_id, 4);
        rdy = 1'b1;
        set_wb(0, 5'd3, 32'hA0);
        set_wb(1, 5'd3, 32'hAB);
        tick();
        idle();
        bus.qry_id = {5'd0, 5'd3};
        #1;
        chk("conflict_rdy", bus.qry_ready[0], 1);
        chk("conflict_val", bus.qry_value[31:0], 32'hAB);

        // store handshake
        do_reset();
        alloc(2'd1, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        tick();
        alloc(2'd0, 5'd7, 1'b1, 32'h55, 1'b0, 32'h0);
        tick();
        idle();
        chk("st_valid_c1", bus.commit_st_valid, 1);
        chk("st_id", bus.commit_id, 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("st_valid_c%0d", i), bus.commit_st_valid, 1);
            chk($sformatf("st_noreg_c%0d", i), bus.commit_reg_valid, 0);
        end
        bus.commit_st_ack = 1'b1;
        tick();
        bus.commit_st_ack = 1'b0;
        chk("st_ack_drop", bus.commit_st_valid, 0);
        chk("st_ack_noreg", bus.commit_reg_valid, 0);
        tick();
        chk("st_next_reg", bus.commit_reg_valid, 1);
        chk("st_next_rd", bus.commit_rd, 7);
        chk("st_next_val", bus.commit_value, 32'h55);
        chk("st_next_id", bus.commit_id, 1);

        // branch mispredict with three younger entries
        do_reset();
        alloc(2'd2, 5'd0, 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        alloc(2'd0, 5'd1, 1'b0, 32'h1, 1'b0, 32'h0);
        tick();
        alloc(2'd0, 5'd2, 1'b0, 32'h2, 1'b0, 32'h0);
        tick();
        alloc(2'd0, 5'd3, 1'b0, 32'h3, 1'b0, 32'h0);
        set_wb(0, 5'd0, 32'h0);
        tick();
        idle();
        chk("br_pre_free_id", bus.rob_free_id, 4);
        chk("br_pre_flush", bus.flush, 0);
        tick();
        chk("br_flush", bus.flush, 1);
        chk("br_redirect", bus.redirect_pc, 32'h100);
        chk("br_free_id", bus.rob_free_id, 0);
        chk("br_full", bus.rob_full, 0);
        alloc(2'd0, 5'd4, 1'b1, 32'h44, 1'b0, 32'h0);
        tick();
        idle();
        chk("br_flush_end", bus.flush, 0);
        chk("br_flush_alloc_drop", bus.rob_free_id, 0);
        bus.qry_id = {5'd1, 5'd0};
        #1;
        chk("br_cleared_q0", bus.qry_ready, 0);

        // EXIT halts until reset
        do_reset();
        alloc(2'd3, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk("exit_halted", bus.halted, 1);
        alloc(2'd0, 5'd1, 1'b1, 32'hCC, 1'b0, 32'h0);
        bus.qry_id = {5'd1, 5'd1};
        #1;
        chk("halt_no_bypass", bus.qry_ready[0], 0);
        tick();
        idle();
        chk("halt_alloc_refused", bus.rob_free_id, 1);
        tick();
        chk("halt_sticky", bus.halted, 1);
        do_reset();
        chk("post_rst_halted", bus.halted, 0);
        chk("post_rst_free_id", bus.rob_free_id, 0);
        alloc(2'd0, 5'd1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        chk("post_rst_alloc", bus.rob_free_id, 1);

        // randomized traffic against the queue model
        do_reset();
        mq.delete();
        m_tail = 0;
        m_flush = 0; m_creg = 0; m_st = 0; m_stwait = 0;
        m_rd = '0; m_cid = '0; m_cval = '0; m_redir = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            bus.commit_st_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 6) begin
                r = $urandom_range(0, 99);
                rty = (r < 70) ? 2'd0 : ((r < 85) ? 2'd1 : 2'd2);
                alloc(rty, 5'($urandom), ($urandom_range(0, 3) == 0), $urandom,
                      1'($urandom), $urandom);
            end
            for (int p = 0; p < 2; p++) begin
                wv[p] = 1'($urandom_range(0, 1));
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    wid[p] = mq[$urandom_range(0, mq.size() - 1)].id;
                else
                    wid[p] = 5'($urandom);
                wval[p] = $urandom;
                if (wv[p]) set_wb(p, wid[p], wval[p]);
            end
            qsel[0] = 5'($urandom);
            qsel[1] = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].id : 5'($urandom);
            bus.qry_id = {qsel[1], qsel[0]};
            #1;

            acc = bus.alloc_valid && (mq.size() < 32) && !m_flush;
            chk("rnd_full", bus.rob_full, (mq.size() == 32));
            chk("rnd_free_id", bus.rob_free_id, m_tail);
            chk("rnd_creg", bus.commit_reg_valid, m_creg);
            if (m_creg) begin
                chk("rnd_rd", bus.commit_rd, m_rd);
                chk("rnd_cval", bus.commit_value, m_cval);
            end
            if (m_creg || m_st) chk("rnd_cid", bus.commit_id, m_cid);
            chk("rnd_st", bus.commit_st_valid, m_st);
            chk("rnd_flush", bus.flush, m_flush);
            if (m_flush) chk("rnd_redir", bus.redirect_pc, m_redir);
            chk("rnd_halted", bus.halted, 0);
            for (int s = 0; s < 2; s++) begin
                known = 0; er = 0; ev = '0;
                if (acc && (m_tail == int'(qsel[s]))) begin
                    er = bus.alloc_ready_val; ev = bus.alloc_value; known = 1;
                end
                for (int p = 1; p >= 0; p--) begin
                    if (!known && wv[p] && wid[p] == qsel[s]) begin
                        er = 1; ev = wval[p]; known = 1;
                    end
                end
                for (int k = 0; k < mq.size(); k++) begin
                    if (!known && mq[k].id == qsel[s]) begin
                        er = mq[k].rdy; ev = mq[k].val; known = 1;
                    end
                end
                chk($sformatf("rnd_qrdy%0d", s), bus.qry_ready[s], er);
                chk($sformatf("rnd_qval%0d", s), bus.qry_value[s*32 +: 32], ev);
            end

            if (rdy) begin
                flush_now = m_flush;
                pop = 0; mis = 0;
                m_creg = 0; m_flush = 0;
                if (mq.size() > 0) begin
                    if (m_stwait) begin
                        if (bus.commit_st_ack) begin
                            pop = 1; m_st = 0; m_stwait = 0;
                        end
                    end else if (mq[0].rdy) begin
                        if (mq[0].ty == 2'd0) begin
                            pop = 1; m_creg = 1; m_rd = mq[0].rd;
                            m_cval = mq[0].val; m_cid = mq[0].id;
                        end else if (mq[0].ty == 2'd1) begin
                            m_st = 1; m_stwait = 1; m_cid = mq[0].id;
                        end else begin
                            pop = 1;
                            if (mq[0].val[0] != mq[0].pred) begin
                                mis = 1; m_redir = mq[0].alt;
                            end
                        end
                    end
                end
                if (!flush_now) begin
                    for (int p = 0; p < 2; p++) begin
                        if (wv[p]) begin
                            for (int k = 0; k < mq.size(); k++) begin
                                if (mq[k].id == wid[p]) begin
                                    mq[k].rdy = 1'b1;
                                    mq[k].val = wval[p];
                                end
                            end
                        end
                    end
                end
                if (acc) begin
                    ne.id   = 5'(m_tail);
                    ne.ty   = bus.alloc_type;
                    ne.rd   = bus.alloc_rd;
                    ne.rdy  = bus.alloc_ready_val;
                    ne.val  = bus.alloc_value;
                    ne.pred = bus.alloc_pred;
                    ne.alt  = bus.alloc_alt_pc;
                    mq.push_back(ne);
                    m_tail = (m_tail + 1) % 32;
                end
                if (pop) void'(mq.pop_front());
                if (mis) begin
                    mq.delete();
                    m_tail = 0;
                    m_flush = 1;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
